// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared bus widths and grant encoding for the memory arbiter.
package cpu_mem_pkg;
  localparam int MEM_ADDR_W    = 19;
  localparam int MEM_DATA_W    = 16;
  localparam int MEM_BYTESEL_W = 2;
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} mem_grant_t;
endpackage

// File: rtl/mem_bus_mux.sv
// mem_bus_mux: steers the granted master's request onto the bus, zeros when idle.
module mem_bus_mux
  import cpu_mem_pkg::*;
(
  input  mem_grant_t               grant_i,
  input  logic [MEM_ADDR_W-1:0]    a_addr_i,
  input  logic [MEM_DATA_W-1:0]    a_data_i,
  input  logic                     a_access_i,
  input  logic                     a_wr_en_i,
  input  logic [MEM_BYTESEL_W-1:0] a_bytesel_i,
  input  logic [MEM_ADDR_W-1:0]    b_addr_i,
  input  logic [MEM_DATA_W-1:0]    b_data_i,
  input  logic                     b_access_i,
  input  logic                     b_wr_en_i,
  input  logic [MEM_BYTESEL_W-1:0] b_bytesel_i,
  output logic [MEM_ADDR_W-1:0]    q_addr_o,
  output logic [MEM_DATA_W-1:0]    q_data_o,
  output logic                     q_access_o,
  output logic                     q_wr_en_o,
  output logic [MEM_BYTESEL_W-1:0] q_bytesel_o
);
  logic sel_a, sel_b;
  always_comb begin
    sel_a       = grant_i == SERVE_A;
    sel_b       = grant_i == SERVE_B;
    q_addr_o    = sel_a ? a_addr_i    : sel_b ? b_addr_i    : '0;
    q_data_o    = sel_a ? a_data_i    : sel_b ? b_data_i    : '0;
    q_access_o  = sel_a ? a_access_i  : sel_b ? b_access_i  : 1'b0;
    q_wr_en_o   = sel_a ? a_wr_en_i   : sel_b ? b_wr_en_i   : 1'b0;
    q_bytesel_o = sel_a ? a_bytesel_i : sel_b ? b_bytesel_i : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (A over B) two-master arbiter onto the 16-bit memory bus.
module mem_arbiter
  import cpu_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MEM_ADDR_W-1:0]    a_m_addr,
  input  logic [MEM_DATA_W-1:0]    a_m_data_out,
  output logic [MEM_DATA_W-1:0]    a_m_data_in,
  input  logic                     a_m_access,
  output logic                     a_m_ack,
  input  logic                     a_m_wr_en,
  input  logic [MEM_BYTESEL_W-1:0] a_m_bytesel,
  input  logic [MEM_ADDR_W-1:0]    b_m_addr,
  input  logic [MEM_DATA_W-1:0]    b_m_data_out,
  output logic [MEM_DATA_W-1:0]    b_m_data_in,
  input  logic                     b_m_access,
  output logic                     b_m_ack,
  input  logic                     b_m_wr_en,
  input  logic [MEM_BYTESEL_W-1:0] b_m_bytesel,
  output logic [MEM_ADDR_W-1:0]    q_m_addr,
  output logic [MEM_DATA_W-1:0]    q_m_data_out,
  input  logic [MEM_DATA_W-1:0]    q_m_data_in,
  output logic                     q_m_access,
  input  logic                     q_m_ack,
  output logic                     q_m_wr_en,
  output logic [MEM_BYTESEL_W-1:0] q_m_bytesel
);
  mem_grant_t grant_q, grant_d;
  logic cur_access;
  always_ff @(posedge clk)
    grant_q <= reset ? IDLE : grant_d;
  // an ack coinciding with reset is swallowed so the abandoned master never sees it
  always_comb begin
    cur_access = (grant_q == SERVE_A) ? a_m_access : b_m_access;
    grant_d    = (grant_q == IDLE) ? (a_m_access ? SERVE_A : b_m_access ? SERVE_B : IDLE)
               : (q_m_ack || !cur_access) ? IDLE : grant_q;
    a_m_ack    = (grant_q == SERVE_A) && q_m_ack && !reset;
    b_m_ack    = (grant_q == SERVE_B) && q_m_ack && !reset;
  end
  assign a_m_data_in = q_m_data_in;
  assign b_m_data_in = q_m_data_in;
  mem_bus_mux u_mux (
    .grant_i    (grant_q),
    .a_addr_i   (a_m_addr),
    .a_data_i   (a_m_data_out),
    .a_access_i (a_m_access),
    .a_wr_en_i  (a_m_wr_en),
    .a_bytesel_i(a_m_bytesel),
    .b_addr_i   (b_m_addr),
    .b_data_i   (b_m_data_out),
    .b_access_i (b_m_access),
    .b_wr_en_i  (b_m_wr_en),
    .b_bytesel_i(b_m_bytesel),
    .q_addr_o   (q_m_addr),
    .q_data_o   (q_m_data_out),
    .q_access_o (q_m_access),
    .q_wr_en_o  (q_m_wr_en),
    .q_bytesel_o(q_m_bytesel)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus randomized run against an ownership model.
module tb_mem_arbiter;
  logic clk = 0, reset;
  logic [18:0] a_m_addr, b_m_addr, q_m_addr;
  logic [15:0] a_m_data_out, b_m_data_out, q_m_data_out, a_m_data_in, b_m_data_in, q_m_data_in;
  logic a_m_access, b_m_access, q_m_access, a_m_ack, b_m_ack, q_m_ack;
  logic a_m_wr_en, b_m_wr_en, q_m_wr_en;
  logic [1:0] a_m_bytesel, b_m_bytesel, q_m_bytesel;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_m_addr(a_m_addr), .a_m_data_out(a_m_data_out), .a_m_data_in(a_m_data_in),
    .a_m_access(a_m_access), .a_m_ack(a_m_ack), .a_m_wr_en(a_m_wr_en), .a_m_bytesel(a_m_bytesel),
    .b_m_addr(b_m_addr), .b_m_data_out(b_m_data_out), .b_m_data_in(b_m_data_in),
    .b_m_access(b_m_access), .b_m_ack(b_m_ack), .b_m_wr_en(b_m_wr_en), .b_m_bytesel(b_m_bytesel),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_data_in(q_m_data_in),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel)
  );
  typedef struct {
    logic rst, aa, ba, qk;
    int   g;
    logic qacc, aack, back;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic rst, aa, ba, qk, int g, logic qacc, aack, back);
    vec_t r;
    r.rst = rst; r.aa = aa; r.ba = ba; r.qk = qk; r.g = g; r.qacc = qacc; r.aack = aack; r.back = back;
    return r;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [37:0] bus_of(int g);
    return g == 1 ? {a_m_addr, a_m_data_out, a_m_wr_en, a_m_bytesel}
         : g == 2 ? {b_m_addr, b_m_data_out, b_m_wr_en, b_m_bytesel} : 38'd0;
  endfunction
  function automatic logic [37:0] bus_now();
    return {q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel};
  endfunction
  initial begin
    int owner;
    logic eacc, eaack, eback;
    a_m_addr = 19'h12345; a_m_data_out = 16'h1111; a_m_wr_en = 0; a_m_bytesel = 2'b11;
    b_m_addr = 19'h00100; b_m_data_out = 16'h5A5A; b_m_wr_en = 1; b_m_bytesel = 2'b01;
    q_m_data_in = 16'hBEEF;
    reset = 1; a_m_access = 0; b_m_access = 0; q_m_ack = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #3;
    chk("reset_qacc", q_m_access, 0);
    chk("reset_acks", {a_m_ack, b_m_ack}, 0);
    chk("reset_bus", bus_now(), 0);
    // single A read with 3 wait states
    tbl.push_back(v(0,1,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0, 1,1,0,0));
    tbl.push_back(v(0,1,0,0, 1,1,0,0));
    tbl.push_back(v(0,1,0,0, 1,1,0,0));
    tbl.push_back(v(0,1,0,1, 1,1,1,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    // simultaneous A and B
    tbl.push_back(v(0,1,1,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,1, 1,1,1,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,0, 2,1,0,0));
    tbl.push_back(v(0,0,1,1, 2,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    // unaligned A pair while B waits
    tbl.push_back(v(0,1,1,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,1, 1,1,1,0));
    tbl.push_back(v(0,1,1,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0, 1,1,0,0));
    tbl.push_back(v(0,1,1,1, 1,1,1,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,1, 2,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    // B abort then late ack
    tbl.push_back(v(0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,0, 2,1,0,0));
    tbl.push_back(v(0,0,0,0, 2,0,0,0));
    tbl.push_back(v(0,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    // reset during SERVE_A with ack in the reset cycle
    tbl.push_back(v(0,1,0,0, 0,0,0,0));
    tbl.push_back(v(1,1,0,1, 1,1,0,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,1, 2,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    // stray ack in IDLE
    tbl.push_back(v(0,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    // ack coinciding with access drop
    tbl.push_back(v(0,1,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,1, 1,0,1,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    foreach (tbl[i]) begin
      @(posedge clk);
      #1 reset = tbl[i].rst; a_m_access = tbl[i].aa; b_m_access = tbl[i].ba; q_m_ack = tbl[i].qk;
      #3;
      chk($sformatf("v%0d_qacc", i), q_m_access, tbl[i].qacc);
      chk($sformatf("v%0d_aack", i), a_m_ack, tbl[i].aack);
      chk($sformatf("v%0d_back", i), b_m_ack, tbl[i].back);
      chk($sformatf("v%0d_bus", i), bus_now(), bus_of(tbl[i].g));
      chk($sformatf("v%0d_rdata", i), {a_m_data_in, b_m_data_in}, {2{16'hBEEF}});
    end
    // random run: owner 0 = nobody, 1 = A, 2 = B
    @(posedge clk);
    #1 reset = 1; a_m_access = 0; b_m_access = 0; q_m_ack = 0;
    owner = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 59) == 0);
      a_m_access = ($urandom_range(0, 2) == 0);
      b_m_access = ($urandom_range(0, 3) != 0);
      q_m_ack = ($urandom_range(0, 2) == 0);
      a_m_addr = 19'($urandom); b_m_addr = 19'($urandom);
      a_m_data_out = 16'($urandom); b_m_data_out = 16'($urandom); q_m_data_in = 16'($urandom);
      a_m_wr_en = 1'($urandom); b_m_wr_en = 1'($urandom);
      a_m_bytesel = 2'($urandom); b_m_bytesel = 2'($urandom);
      #3;
      eacc  = owner == 1 ? a_m_access : owner == 2 ? b_m_access : 1'b0;
      eaack = owner == 1 && q_m_ack && !reset;
      eback = owner == 2 && q_m_ack && !reset;
      chk("rnd_qacc", q_m_access, eacc);
      chk("rnd_aack", a_m_ack, eaack);
      chk("rnd_back", b_m_ack, eback);
      chk("rnd_bus", bus_now(), bus_of(owner));
      chk("rnd_rdata", {a_m_data_in, b_m_data_in}, {2{q_m_data_in}});
      if (reset) owner = 0;
      else if (owner == 0) owner = a_m_access ? 1 : b_m_access ? 2 : 0;
      else if (q_m_ack || !eacc) owner = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
